quad_byte_dispatch: RTL and testbench
=====================================

Name: quad_byte_dispatch

Overview:
- Buffered 1-to-4 byte demultiplexer; the write-side counterpart of the 4-to-1 byte source selector.
- Accepts a byte tagged with the same {sel1, sel0} select code the selector uses, queues it, and delivers it to exactly one of four destination channels (a, b, c, d) over a valid/ready handshake.
- Sits between the shared 8-bit data bus and the four destination registers/units.

Parameters:
- WIDTH, 8, data width in bits.
- DEPTH, 4, FIFO entries. Must be a power of 2, minimum 2.
- CNTW, 8, width of each per-destination delivery counter (optional feature only).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous clear of FIFO contents.
- in_data  input  WIDTH  byte to route.
- in_sel0  input  1  select bit 0; 1 selects a or c.
- in_sel1  input  1  select bit 1; 1 selects a or b.
- in_valid  input  1  producer offers in_data/in_sel*.
- in_ready  output  1  block can accept an entry.
- out_data  output  WIDTH  head-entry byte, shared by all channels.
- out_valid  output  4  one-hot channel valid: bit3=a, bit2=b, bit1=c, bit0=d.
- out_ready  input  4  per-channel ready, same bit order.
- level  output  log2(DEPTH)+1  current FIFO occupancy.
- stat_count  output  4*CNTW  per-channel delivery counters: [4*CNTW-1 -: CNTW]=a … [CNTW-1:0]=d.

Behaviour:
- Decode mapping, identical to the selector's:
  - {sel1,sel0}=11 → a
  - 10 → b
  - 01 → c
  - 00 → d
- Reset (async, rst=1): FIFO empty, level=0, in_ready=1, out_valid=4'b0000, out_data=0, stat_count=0.
- Push: occurs on a clock edge with in_valid & in_ready. The stored entry is {in_data, in_sel1, in_sel0}.
- in_ready = (level != DEPTH), registered-independent.
  - Full blocks a push even if a pop occurs in the same cycle; there is no pass-through when full.
- Latency: an entry pushed at edge N presents at earliest in the cycle after edge N (level was 0). There is no combinational in→out fall-through.
- Head presentation while level>0:
  - out_data = head byte.
  - out_valid = one-hot decode of head select; all other bits 0.
- While level=0: out_valid=0 and out_data holds its last value.
- Pop: occurs on an edge where out_valid[k] & out_ready[k] for the decoded k.
  - out_ready on non-selected channels is ignored.
  - Head-of-line blocking is intended: a stalled channel stalls all channels.
- Simultaneous push and pop (level strictly between 0 and DEPTH): level unchanged; order preserved.
- Push when empty plus no pop: level 0→1.
- Pop on the last entry plus a simultaneous push: level stays 1; the new entry becomes head next cycle.
- Pointers: wrap modulo DEPTH. level counts 0..DEPTH inclusive and never exceeds DEPTH.
- Stability rule: once out_valid[k] rises, out_data and out_valid stay stable until pop, flush, or reset.
- flush=1 at an edge:
  - level←0, pointers←0, out_valid←0.
  - A concurrent push is discarded.
  - A concurrent pop is not counted.
- Reset mid-transfer: entry lost, outputs return to reset values asynchronously.

Optional Feature:
- Macro: QUAD_BYTE_DISPATCH_STATS_EN.
- Defined:
  - Each channel has a CNTW-bit counter that increments on each pop to that channel.
  - Counters saturate at all-ones.
  - Cleared by rst only; flush does not clear them.
- Undefined:
  - stat_count is tied to 0.
  - No counter flops are instantiated.

Test Plan:
- Reset then push {0x3C, sel=11} with out_ready=4'b1111 → next cycle out_valid=4'b1000, out_data=0x3C. Popped on the following edge, after which level=0.
- Push 0xA1/11, 0xB2/10, 0xC3/01, 0xD4/00 back-to-back with out_ready=0 → level=4, in_ready=0. A fifth push is not accepted. Raising out_ready=1111 drains in order with out_valid 1000, 0100, 0010, 0001.
- Head 0x55 → b with out_ready=4'b1011 (b low) for 5 cycles → out_valid=0100 held, out_data=0x55 stable, level unchanged. Set bit2 → pop.
- level=2 with simultaneous push and pop for 10 cycles → level stays 2. Output order equals push order, including across pointer wrap.
- level=3 then flush=1 with in_valid=1 → next cycle level=0, out_valid=0, in_ready=1. The pushed byte never appears.
- With QUAD_BYTE_DISPATCH_STATS_EN and CNTW=8: 300 pops to channel c → stat_count c-field=0xFF, other fields 0. Assert rst → all fields 0.

Source files
------------

// File: rtl/quad_byte_dispatch_if.sv
// ---------------------------------------------------------------------------
// quad_byte_dispatch_if
// Bus bundle for the buffered 1-to-4 byte dispatcher.
//   flush       : synchronous clear of the queued entries
//   in_*        : producer side (byte, 2-bit select code, valid/ready)
//   out_data    : head byte, shared by all four channels
//   out_valid   : one-hot channel valid, bit3=a bit2=b bit1=c bit0=d
//   out_ready   : per-channel ready, same bit order
//   level       : queue occupancy, 0..DEPTH
//   stat_count  : per-channel delivery counters, a in the top field
// Modports:
//   master : environment side (drives producer inputs and channel readies)
//   slave  : the dispatcher itself
// ---------------------------------------------------------------------------
interface quad_byte_dispatch_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CNTW  = 8
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic              flush;
  logic [WIDTH-1:0]  in_data;
  logic              in_sel0;
  logic              in_sel1;
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  out_data;
  logic [3:0]        out_valid;
  logic [3:0]        out_ready;
  logic [LW-1:0]     level;
  logic [4*CNTW-1:0] stat_count;

  modport master (
    output flush, in_data, in_sel0, in_sel1, in_valid, out_ready,
    input  in_ready, out_data, out_valid, level, stat_count
  );

  modport slave (
    input  flush, in_data, in_sel0, in_sel1, in_valid, out_ready,
    output in_ready, out_data, out_valid, level, stat_count
  );
endinterface

// File: rtl/quad_byte_dispatch.sv
// ---------------------------------------------------------------------------
// quad_byte_dispatch
// Buffered 1-to-4 byte demultiplexer. A byte tagged with a {sel1,sel0} code
// is queued in a DEPTH-entry FIFO and delivered to exactly one of the four
// channels a/b/c/d (11->a, 10->b, 01->c, 00->d) over valid/ready.
// The head entry is presented from registers, so a byte pushed at edge N is
// visible at the earliest in the cycle after edge N; there is no
// combinational input-to-output path. A stalled head blocks all channels.
//
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : quad_byte_dispatch_if.slave (flush, producer and channel signals)
//
// Optional feature: define QUAD_BYTE_DISPATCH_STATS_EN to build saturating
// per-channel delivery counters (cleared by rst only). Without it
// stat_count is tied to zero and no counter flops exist.
// ---------------------------------------------------------------------------
module quad_byte_dispatch #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,   // power of two, at least 2
  parameter int CNTW  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  quad_byte_dispatch_if.slave    bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int EW = WIDTH + 2;   // stored entry: {data, sel1, sel0}

  localparam logic [PW-1:0] PTR_ONE   = PW'(1'b1);
  localparam logic [LW-1:0] LVL_ONE   = LW'(1'b1);
  localparam logic [LW-1:0] LVL_FULL  = LW'(DEPTH);

  // Select code to one-hot channel valid; the mapping matches the 4-to-1
  // source selector so one code names the same unit in both directions.
  function automatic logic [3:0] decode_sel(input logic [1:0] sel);
    logic [3:0] oh;
    case (sel)
      2'b11:   oh = 4'b1000;
      2'b10:   oh = 4'b0100;
      2'b01:   oh = 4'b0010;
      2'b00:   oh = 4'b0001;
      default: oh = 4'b0000;
    endcase
    return oh;
  endfunction

  logic [EW-1:0]    mem_r [DEPTH];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [LW-1:0]    level_r;
  logic             in_ready_r;
  logic [3:0]       out_valid_r;
  logic [WIDTH-1:0] out_data_r;

  logic             push_s;
  logic             pop_s;
  logic [PW-1:0]    wr_ptr_nxt_s;
  logic [PW-1:0]    rd_ptr_nxt_s;
  logic [LW-1:0]    level_nxt_s;
  logic [EW-1:0]    in_entry_s;
  logic [EW-1:0]    head_nxt_s;

  // Handshake qualification and next pointer/occupancy values.
  always_comb begin
    in_entry_s   = {bus.in_data, bus.in_sel1, bus.in_sel0};
    // in_ready_r already excludes the full case, so full blocks a push even
    // when a pop happens on the same edge.
    push_s       = bus.in_valid & in_ready_r & ~bus.flush;
    // out_valid_r is one-hot, so ready on a non-selected channel is masked.
    pop_s        = (|(out_valid_r & bus.out_ready)) & ~bus.flush;
    wr_ptr_nxt_s = wr_ptr_r;
    rd_ptr_nxt_s = rd_ptr_r;
    level_nxt_s  = level_r;
    if (bus.flush) begin
      wr_ptr_nxt_s = {PW{1'b0}};
      rd_ptr_nxt_s = {PW{1'b0}};
      level_nxt_s  = {LW{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
      end else begin
        wr_ptr_nxt_s = wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
      end else begin
        rd_ptr_nxt_s = rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   level_nxt_s = level_r + LVL_ONE;
        2'b01:   level_nxt_s = level_r - LVL_ONE;
        default: level_nxt_s = level_r;
      endcase
    end
  end

  // Entry that will sit at the head after this edge. When the incoming
  // entry lands exactly at the next read slot (push into empty, or push
  // while popping the last entry) it is taken straight from the input.
  always_comb begin
    head_nxt_s = mem_r[rd_ptr_nxt_s];
    if (push_s && (wr_ptr_r == rd_ptr_nxt_s)) begin
      head_nxt_s = in_entry_s;
    end else begin
      head_nxt_s = mem_r[rd_ptr_nxt_s];
    end
  end

  // FIFO storage write port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {EW{1'b0}};
      end
    end else if (push_s) begin
      mem_r[wr_ptr_r] <= in_entry_s;
    end
  end

  // Pointer, occupancy and head-presentation registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r    <= {PW{1'b0}};
      rd_ptr_r    <= {PW{1'b0}};
      level_r     <= {LW{1'b0}};
      in_ready_r  <= 1'b1;
      out_valid_r <= 4'b0000;
      out_data_r  <= {WIDTH{1'b0}};
    end else begin
      wr_ptr_r   <= wr_ptr_nxt_s;
      rd_ptr_r   <= rd_ptr_nxt_s;
      level_r    <= level_nxt_s;
      in_ready_r <= (level_nxt_s != LVL_FULL);
      if (level_nxt_s != {LW{1'b0}}) begin
        out_valid_r <= decode_sel(head_nxt_s[1:0]);
        out_data_r  <= head_nxt_s[EW-1:2];
      end else begin
        // Empty: drop valid but keep the last byte on the bus.
        out_valid_r <= 4'b0000;
      end
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
  assign bus.level     = level_r;

`ifdef QUAD_BYTE_DISPATCH_STATS_EN
  // Counter k pairs with out_valid[k], so d lives in the lowest field.
  logic [CNTW-1:0]   cnt_r [4];
  logic [4*CNTW-1:0] stat_count_s;

  // Saturating delivery counters; flush never reaches here because pop_s
  // is already suppressed during flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) begin
        cnt_r[k] <= {CNTW{1'b0}};
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (pop_s && out_valid_r[k] && (cnt_r[k] != {CNTW{1'b1}})) begin
          cnt_r[k] <= cnt_r[k] + CNTW'(1'b1);
        end
      end
    end
  end

  // Pack the counters onto the flat statistics bus.
  always_comb begin
    stat_count_s = {(4*CNTW){1'b0}};
    for (int k = 0; k < 4; k++) begin
      stat_count_s[k*CNTW +: CNTW] = cnt_r[k];
    end
  end

  assign bus.stat_count = stat_count_s;
`else
  assign bus.stat_count = {(4*CNTW){1'b0}};
`endif

endmodule

// File: tb/tb_quad_byte_dispatch.sv
// ---------------------------------------------------------------------------
// tb_quad_byte_dispatch
// Directed bench for quad_byte_dispatch (WIDTH=8, DEPTH=4, CNTW=8).
// Stimulus tasks push the hand-computed expected {byte, channel} into a
// queue when a push is accepted; an independent monitor pops and compares
// whenever a channel transfer completes. Status signals are checked inline.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_quad_byte_dispatch;

  typedef struct packed {
    logic [7:0] data;
    logic [3:0] ch;
  } exp_t;

  // Expected one-hot by select code, written out by hand: 00->d ... 11->a.
  localparam logic [3:0] OH_D = 4'b0001;
  localparam logic [3:0] OH_C = 4'b0010;
  localparam logic [3:0] OH_B = 4'b0100;
  localparam logic [3:0] OH_A = 4'b1000;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;
  exp_t exp_q[$];

  quad_byte_dispatch_if #(.WIDTH(8), .DEPTH(4), .CNTW(8)) bus ();

  quad_byte_dispatch #(.WIDTH(8), .DEPTH(4), .CNTW(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1, "timeout");
  end

  // Scoreboard monitor: a transfer completes at the next rising edge.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && !bus.flush && ((bus.out_valid & bus.out_ready) != 4'b0000)) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_out: got data=%02h ch=%b, expected no transfer",
                 bus.out_data, bus.out_valid);
      end else begin
        e = exp_q.pop_front();
        if (bus.out_data !== e.data || bus.out_valid !== e.ch) begin
          n_err++;
          $display("FAIL out_entry: got data=%02h ch=%b, expected data=%02h ch=%b",
                   bus.out_data, bus.out_valid, e.data, e.ch);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Offer one entry until accepted; record the expectation on acceptance.
  task automatic push(input logic [7:0] d, input logic [1:0] s, input logic [3:0] ch);
    bit   done;
    exp_t e;
    done         = 1'b0;
    bus.in_data  = d;
    bus.in_sel1  = s[1];
    bus.in_sel0  = s[0];
    bus.in_valid = 1'b1;
    for (int t = 0; t < 50 && !done; t++) begin
      @(negedge clk);
      if (bus.in_ready && !bus.flush) begin
        e.data = d;
        e.ch   = ch;
        exp_q.push_back(e);
        done   = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    if (!done) begin
      n_cmp++;
      n_err++;
      $display("FAIL push_timeout: byte %02h not accepted, expected acceptance", d);
    end
  endtask

  task automatic wait_drain(input int budget);
    int t;
    t = 0;
    while ((exp_q.size() != 0 || bus.level != 3'd0) && t < budget) begin
      cyc(1);
      t++;
    end
    if (t >= budget) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout: level=%0d pending=%0d, expected 0/0", bus.level, exp_q.size());
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    exp_q.delete();
    check("rst_level",     32'(bus.level),      32'd0);
    check("rst_in_ready",  32'(bus.in_ready),   32'd1);
    check("rst_out_valid", 32'(bus.out_valid),  32'd0);
    check("rst_out_data",  32'(bus.out_data),   32'd0);
    check("rst_stat",      bus.stat_count,      32'd0);
    cyc(1);
    rst = 1'b0;
    cyc(1);
  endtask

  initial begin
    n_cmp         = 0;
    n_err         = 0;
    rst           = 1'b1;
    bus.flush     = 1'b0;
    bus.in_data   = 8'h00;
    bus.in_sel0   = 1'b0;
    bus.in_sel1   = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 4'b0000;
    cyc(2);
    do_reset();

    // Single byte to a, one-cycle latency, popped on the following edge.
    bus.out_ready = 4'b1111;
    push(8'h3C, 2'b11, OH_A);
    check("t1_valid", 32'(bus.out_valid), 32'h8);
    check("t1_data",  32'(bus.out_data),  32'h3C);
    cyc(1);
    check("t1_level_after_pop", 32'(bus.level), 32'd0);
    check("t1_valid_after_pop", 32'(bus.out_valid), 32'd0);
    check("t1_data_held", 32'(bus.out_data), 32'h3C);

    // Fill to full, fifth push refused, then drain in order.
    bus.out_ready = 4'b0000;
    push(8'hA1, 2'b11, OH_A);
    push(8'hB2, 2'b10, OH_B);
    push(8'hC3, 2'b01, OH_C);
    push(8'hD4, 2'b00, OH_D);
    check("t2_level_full", 32'(bus.level),    32'd4);
    check("t2_in_ready",   32'(bus.in_ready), 32'd0);
    bus.in_data  = 8'hEE;
    bus.in_sel1  = 1'b0;
    bus.in_sel0  = 1'b0;
    bus.in_valid = 1'b1;
    cyc(2);
    bus.in_valid = 1'b0;
    check("t2_level_still_full", 32'(bus.level), 32'd4);
    check("t2_head_data",  32'(bus.out_data),  32'hA1);
    check("t2_head_valid", 32'(bus.out_valid), 32'h8);
    bus.out_ready = 4'b1111;
    wait_drain(20);

    // Head to b stalled by its own ready; other readies ignored.
    bus.out_ready = 4'b1011;
    push(8'h55, 2'b10, OH_B);
    for (int i = 0; i < 5; i++) begin
      check("t3_stall_valid", 32'(bus.out_valid), 32'h4);
      check("t3_stall_data",  32'(bus.out_data),  32'h55);
      check("t3_stall_level", 32'(bus.level),     32'd1);
      cyc(1);
    end
    bus.out_ready = 4'b1111;
    cyc(1);
    check("t3_level_after_pop", 32'(bus.level), 32'd0);

    // Level 2 with concurrent push/pop for 10 cycles, across pointer wrap.
    bus.out_ready = 4'b0000;
    push(8'h10, 2'b11, OH_A);
    push(8'h20, 2'b10, OH_B);
    check("t4_level_start", 32'(bus.level), 32'd2);
    bus.out_ready = 4'b1111;
    for (int i = 0; i < 10; i++) begin
      logic [1:0] s;
      logic [3:0] oh;
      s  = 2'(i);
      oh = (s == 2'b11) ? OH_A : (s == 2'b10) ? OH_B : (s == 2'b01) ? OH_C : OH_D;
      push(8'h30 + 8'(i), s, oh);
      check("t4_level_steady", 32'(bus.level), 32'd2);
    end
    wait_drain(20);

    // Flush at level 3 with a concurrent push: everything discarded.
    bus.out_ready = 4'b0000;
    push(8'h71, 2'b11, OH_A);
    push(8'h72, 2'b10, OH_B);
    push(8'h73, 2'b01, OH_C);
    check("t5_level_3", 32'(bus.level), 32'd3);
    bus.flush    = 1'b1;
    bus.in_data  = 8'h99;
    bus.in_sel1  = 1'b0;
    bus.in_sel0  = 1'b1;
    bus.in_valid = 1'b1;
    cyc(1);
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    exp_q.delete();
    check("t5_level",     32'(bus.level),     32'd0);
    check("t5_valid",     32'(bus.out_valid), 32'd0);
    check("t5_in_ready",  32'(bus.in_ready),  32'd1);
    check("t5_data_held", 32'(bus.out_data),  32'h71);
    bus.out_ready = 4'b1111;
    cyc(3);
    check("t5_no_ghost", 32'(bus.out_valid), 32'd0);

`ifdef QUAD_BYTE_DISPATCH_STATS_EN
    // Saturating counter on channel c.
    do_reset();
    bus.out_ready = 4'b1111;
    for (int i = 0; i < 10; i++) begin
      push(8'(i), 2'b01, OH_C);
    end
    wait_drain(20);
    check("t6_stat_10", bus.stat_count, 32'h0000_0A00);
    for (int i = 10; i < 300; i++) begin
      push(8'(i), 2'b01, OH_C);
    end
    wait_drain(20);
    check("t6_stat_sat", bus.stat_count, 32'h0000_FF00);
    bus.flush = 1'b1;
    cyc(1);
    bus.flush = 1'b0;
    check("t6_stat_after_flush", bus.stat_count, 32'h0000_FF00);
    do_reset();
`else
    check("t6_stat_tied", bus.stat_count, 32'd0);
`endif

    check("end_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
